exec_clock_ctrl: RTL and testbench
==================================

EXEC_CLOCK_CTRL -- requirements
Module: exec_clock_ctrl

Interface
REQ-001 SHALL have parameter DIV_RATIO, default 50000000, slow-run clock-enable period in Clk cycles (>=2).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 500000, stable cycles required to accept a StepBtn level change (>=1).
REQ-003 SHALL have parameter CNT_WIDTH, default 32, width of CycleCount.
REQ-004 SHALL have port Clk, input, 1, single clock; all logic on rising edge.
REQ-005 SHALL have port Reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port Play, input, 1, run switch, asynchronous to Clk.
REQ-007 SHALL have port FullSpeed, input, 1, 1 = full-rate run, 0 = divided run, asynchronous.
REQ-008 SHALL have port StepBtn, input, 1, single-step pushbutton, asynchronous, bouncy.
REQ-009 SHALL have port BreakHalt, input, 1, Clk-synchronous halt request from the processor.
REQ-010 SHALL have port ClearCount, input, 1, Clk-synchronous cycle-counter clear.
REQ-011 SHALL have port CpuEn, output, 1, processor clock enable.
REQ-012 SHALL have port Mode, output, 2, current state: 0 HALT, 1 STEP, 2 RUN_SLOW, 3 RUN_FULL.
REQ-013 SHALL have port CycleCount, output, CNT_WIDTH, count of enabled processor cycles.

Function
REQ-014 SHALL pass Play, FullSpeed and StepBtn each through a 2-flop synchroniser before use; a Play/FullSpeed change SHALL be reflected in Mode at the 3rd rising Clk edge after the change.
REQ-015 SHALL accept a new debounced StepBtn level only after the synchronised level differs from it for DEBOUNCE_CYCLES consecutive cycles; any reversion restarts the count.
REQ-016 SHALL produce a one-cycle step pulse on each 0->1 transition of the debounced StepBtn level.
REQ-017 SHALL hold a break latch, set when BreakHalt=1 in RUN_SLOW or RUN_FULL and cleared when synchronised Play=0.
REQ-018 HALT: step pulse -> STEP; else Play=1 and latch clear -> RUN_FULL if FullSpeed=1, RUN_SLOW if 0; else stay.
REQ-019 STEP: SHALL last exactly one cycle and return to HALT unconditionally.
REQ-020 RUN_SLOW/RUN_FULL: BreakHalt=1 or Play=0 -> HALT (highest priority); else FullSpeed selects RUN_FULL/RUN_SLOW.
REQ-021 Step pulses outside HALT SHALL be discarded.
REQ-022 Divider SHALL reset to 0 on every entry to RUN_SLOW, count 0..DIV_RATIO-1 and wrap to 0.
REQ-023 CpuEn SHALL be 1 when Mode=STEP, when Mode=RUN_FULL, or when Mode=RUN_SLOW and divider=DIV_RATIO-1; else 0; decoded from registers only (glitch-free).
REQ-024 CycleCount SHALL increment by 1 in each cycle with CpuEn=1 and wrap from all-ones to 0.
REQ-025 ClearCount=1 SHALL load CycleCount with 0 and take priority over increment in the same cycle.
REQ-026 BreakHalt in the same cycle as a RUN_FULL CpuEn SHALL not suppress that cycle's CpuEn; the next cycle SHALL be HALT with CpuEn=0.

Reset
REQ-027 Reset=1 SHALL immediately force Mode=HALT, CpuEn=0, CycleCount=0, divider=0, break latch clear, debounced level 0, debounce counter 0, synchronisers 0.
REQ-028 Reset asserted mid-run or mid-debounce SHALL abort it; after release a StepBtn held high SHALL yield one step pulse only after full debounce.

Configuration
REQ-029 Macro EXEC_CYCLE_COUNTER_EN: defined -> CycleCount behaves per REQ-024/025; undefined -> counter logic absent, CycleCount constant 0, ClearCount ignored.

Verification (DIV_RATIO=4, DEBOUNCE_CYCLES=3, CNT_WIDTH=8)
REQ-030 Play=1, FullSpeed=0 from reset -> Mode=2 after 3 edges, CpuEn high every 4th cycle, CycleCount=5 after 20 cycles in RUN_SLOW.
REQ-031 HALT, StepBtn bounces 1,0,1 then held 1 for 10 cycles -> exactly one STEP cycle, one CpuEn pulse, CycleCount +1.
REQ-032 RUN_FULL, BreakHalt=1 one cycle -> HALT next cycle; Play held 1 stays HALT; Play 0 then 1 -> RUN_FULL.
REQ-033 RUN_FULL with CycleCount=254 for 3 cycles -> 255, 0, 1; ClearCount=1 with CpuEn=1 -> 0.
REQ-034 Reset pulsed during RUN_FULL mid-cycle -> CpuEn=0, Mode=0, CycleCount=0 before next Clk edge.

Source files
------------

// File: rtl/exec_clock_ctrl.sv
// exec_clock_ctrl: processor clock-enable controller (halt / single-step /
// divided run / full-rate run) with input synchronisers, step debounce,
// break latch and an enabled-cycle counter.
// Optional feature: define EXEC_CYCLE_COUNTER_EN to build the cycle counter;
// without it CycleCount is tied to 0 and ClearCount is ignored.
module exec_clock_ctrl #(
  parameter int unsigned DIV_RATIO       = 50000000,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_WIDTH       = 32
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Play,
  input  logic                 FullSpeed,
  input  logic                 StepBtn,
  input  logic                 BreakHalt,
  input  logic                 ClearCount,
  output logic                 CpuEn,
  output logic [1:0]           Mode,
  output logic [CNT_WIDTH-1:0] CycleCount
);

  localparam int unsigned DIV_W = (DIV_RATIO > 1) ? $clog2(DIV_RATIO) : 1;
  localparam int unsigned DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_RATIO - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    HALT     = 2'd0,
    STEP     = 2'd1,
    RUN_SLOW = 2'd2,
    RUN_FULL = 2'd3
  } mode_e;

  mode_e            state;
  logic [1:0]       play_sync;
  logic [1:0]       fs_sync;
  logic [1:0]       step_sync;
  logic             play_s;
  logic             fs_s;
  logic             step_s;
  logic             deb_level;
  logic [DEB_W-1:0] deb_cnt;
  logic             step_pulse;
  logic             break_latch;
  logic [DIV_W-1:0] div_cnt;

  assign play_s = play_sync[1];
  assign fs_s   = fs_sync[1];
  assign step_s = step_sync[1];

  // Two-flop synchronisers for the asynchronous panel inputs
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      play_sync <= 2'b00;
      fs_sync   <= 2'b00;
      step_sync <= 2'b00;
    end else begin
      play_sync <= {play_sync[0], Play};
      fs_sync   <= {fs_sync[0], FullSpeed};
      step_sync <= {step_sync[0], StepBtn};
    end
  end

  // Step debounce: accept a new level after it holds for DEBOUNCE_CYCLES
  // consecutive cycles; the rising acceptance produces a one-cycle pulse
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      deb_level  <= 1'b0;
      deb_cnt    <= '0;
      step_pulse <= 1'b0;
    end else if (step_s != deb_level) begin
      if (deb_cnt == DEB_LAST) begin
        deb_level  <= step_s;
        deb_cnt    <= '0;
        step_pulse <= step_s;
      end else begin
        deb_cnt    <= deb_cnt + DEB_W'(1);
        step_pulse <= 1'b0;
      end
    end else begin
      deb_cnt    <= '0;
      step_pulse <= 1'b0;
    end
  end

  // Mode FSM with break latch and slow-run divider (divider restarts at 0
  // on every entry into RUN_SLOW and only advances while staying there)
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= HALT;
      div_cnt     <= '0;
      break_latch <= 1'b0;
    end else begin
      div_cnt <= '0;

      if (!play_s) begin
        break_latch <= 1'b0;
      end else if (BreakHalt && (state == RUN_SLOW || state == RUN_FULL)) begin
        break_latch <= 1'b1;
      end

      case (state)
        HALT: begin
          if (step_pulse) begin
            state <= STEP;
          end else if (play_s && !break_latch) begin
            state <= fs_s ? RUN_FULL : RUN_SLOW;
          end
        end
        STEP: begin
          state <= HALT;
        end
        RUN_SLOW, RUN_FULL: begin
          if (BreakHalt || !play_s) begin
            state <= HALT;
          end else if (fs_s) begin
            state <= RUN_FULL;
          end else begin
            state <= RUN_SLOW;
            if (state == RUN_SLOW) begin
              div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
            end
          end
        end
        default: begin
          state <= HALT;
        end
      endcase
    end
  end

  // Clock enable decoded purely from state registers so it cannot glitch
  assign CpuEn = (state == STEP) || (state == RUN_FULL) ||
                 ((state == RUN_SLOW) && (div_cnt == DIV_LAST));
  assign Mode  = state;

`ifdef EXEC_CYCLE_COUNTER_EN
  logic [CNT_WIDTH-1:0] cycle_cnt;

  // Enabled-cycle counter; clear wins over increment
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cycle_cnt <= '0;
    end else if (ClearCount) begin
      cycle_cnt <= '0;
    end else if (CpuEn) begin
      cycle_cnt <= cycle_cnt + CNT_WIDTH'(1);
    end
  end

  assign CycleCount = cycle_cnt;
`else
  logic unused_clear_count;

  assign unused_clear_count = ClearCount;
  assign CycleCount         = '0;
`endif

endmodule

// File: tb/tb_exec_clock_ctrl.sv
// Bench for exec_clock_ctrl: directed scenarios followed by random panel
// activity, all compared against a behavioural model of the mode rules.
module tb_exec_clock_ctrl;

  localparam int DIV   = 4;
  localparam int DEB   = 3;
  localparam int CNT_W = 8;

  logic             Clk;
  logic             Reset;
  logic             Play;
  logic             FullSpeed;
  logic             StepBtn;
  logic             BreakHalt;
  logic             ClearCount;
  logic             CpuEn;
  logic [1:0]       Mode;
  logic [CNT_W-1:0] CycleCount;

  int n_vec;
  int n_err;

  exec_clock_ctrl #(
    .DIV_RATIO      (DIV),
    .DEBOUNCE_CYCLES(DEB),
    .CNT_WIDTH      (CNT_W)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Play      (Play),
    .FullSpeed (FullSpeed),
    .StepBtn   (StepBtn),
    .BreakHalt (BreakHalt),
    .ClearCount(ClearCount),
    .CpuEn     (CpuEn),
    .Mode      (Mode),
    .CycleCount(CycleCount)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Behavioural model: modes 0 HALT, 1 STEP, 2 RUN_SLOW, 3 RUN_FULL
  int m_mode, m_age, m_lvl, m_run, m_pulse, m_latch, m_cnt, m_en;
  int play_q[$], fs_q[$], step_q[$];

  function automatic int cexp(input int v);
`ifdef EXEC_CYCLE_COUNTER_EN
    return v;
`else
    return 0;
`endif
  endfunction

  function automatic int en_of(input int md, input int age);
    if (md == 1 || md == 3) return 1;
    if (md == 2 && (age % DIV) == DIV - 1) return 1;
    return 0;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_age = 0; m_lvl = 0; m_run = 0; m_pulse = 0;
    m_latch = 0; m_cnt = 0; m_en = 0;
    play_q = '{0, 0};
    fs_q   = '{0, 0};
    step_q = '{0, 0};
  endtask

  // One rising edge of the model, using the inputs present before the edge
  task automatic model_edge();
    int p, f, s, old_en, nxt, pu, nl;
    if (Reset) begin
      model_reset();
      return;
    end
    p = play_q[0];
    f = fs_q[0];
    s = step_q[0];
    old_en = en_of(m_mode, m_age);
    pu = m_pulse;

    m_pulse = 0;
    if (s != m_lvl) begin
      m_run++;
      if (m_run >= DEB) begin
        m_lvl = s;
        m_run = 0;
        m_pulse = s;
      end
    end else begin
      m_run = 0;
    end

    nl = m_latch;
    if (p == 0) nl = 0;
    else if (BreakHalt && (m_mode == 2 || m_mode == 3)) nl = 1;

    nxt = m_mode;
    case (m_mode)
      0: if (pu != 0) nxt = 1;
         else if (p != 0 && m_latch == 0) nxt = (f != 0) ? 3 : 2;
      1: nxt = 0;
      default: if (BreakHalt || p == 0) nxt = 0;
               else nxt = (f != 0) ? 3 : 2;
    endcase

    m_age = (nxt == 2 && m_mode == 2) ? m_age + 1 : 0;
`ifdef EXEC_CYCLE_COUNTER_EN
    if (ClearCount) m_cnt = 0;
    else if (old_en != 0) m_cnt = (m_cnt + 1) % (1 << CNT_W);
`endif
    m_latch = nl;
    m_mode = nxt;
    m_en = en_of(m_mode, m_age);

    void'(play_q.pop_front()); play_q.push_back(int'(Play));
    void'(fs_q.pop_front());   fs_q.push_back(int'(FullSpeed));
    void'(step_q.pop_front()); step_q.push_back(int'(StepBtn));
  endtask

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    assert (act === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance one clock, update model, compare all outputs away from the edge
  task automatic tick();
    @(posedge Clk);
    model_edge();
    #1;
    check("mode", 32'(Mode), 32'(m_mode));
    check("cpu_en", 32'(CpuEn), 32'(m_en));
    check("cycle_count", 32'(CycleCount), 32'(m_cnt));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int steps, ens, c0;
    n_vec = 0;
    n_err = 0;
    Reset = 1'b0; Play = 1'b0; FullSpeed = 1'b0; StepBtn = 1'b0;
    BreakHalt = 1'b0; ClearCount = 1'b0;
    model_reset();
    #1 Reset = 1'b1;
    #1;
    check("reset_mode", 32'(Mode), 32'd0);
    check("reset_cpu_en", 32'(CpuEn), 32'd0);
    check("reset_count", 32'(CycleCount), 32'd0);
    ticks(2);
    Reset = 1'b0;

    // Divided run from reset
    Play = 1'b1; FullSpeed = 1'b0;
    ticks(2);
    check("slow_not_yet", 32'(Mode), 32'd0);
    tick();
    check("slow_entered", 32'(Mode), 32'd2);
    for (int k = 1; k <= 20; k++) begin
      tick();
      check("slow_en_pattern", 32'(CpuEn), (k % 4 == 3) ? 32'd1 : 32'd0);
    end
    check("slow_count_20", 32'(CycleCount), 32'(cexp(5)));

    // Bouncy step button in HALT
    Play = 1'b0;
    ticks(4);
    check("halt_after_play_off", 32'(Mode), 32'd0);
    c0 = m_cnt;
    steps = 0; ens = 0;
    for (int i = 0; i < 19; i++) begin
      StepBtn = (i == 1 || i >= 13) ? 1'b0 : 1'b1;
      tick();
      if (Mode == 2'd1) steps++;
      if (CpuEn) ens++;
    end
    check("step_cycles", 32'(steps), 32'd1);
    check("step_en_pulses", 32'(ens), 32'd1);
    check("step_count_inc", 32'(CycleCount), 32'(cexp(c0 + 1)));

    // Full-rate run, break, re-arm via Play
    Play = 1'b1; FullSpeed = 1'b1;
    ticks(3);
    check("full_entered", 32'(Mode), 32'd3);
    ticks(4);
    check("full_en_before_break", 32'(CpuEn), 32'd1);
    c0 = m_cnt;
    BreakHalt = 1'b1;
    tick();
    BreakHalt = 1'b0;
    check("break_halt_mode", 32'(Mode), 32'd0);
    check("break_halt_en", 32'(CpuEn), 32'd0);
    check("break_keeps_last_en", 32'(CycleCount), 32'(cexp((c0 + 1) % 256)));
    ticks(6);
    check("break_latched", 32'(Mode), 32'd0);
    Play = 1'b0;
    ticks(4);
    Play = 1'b1;
    ticks(3);
    check("rearm_full", 32'(Mode), 32'd3);

    // Counter wrap and clear priority
    ClearCount = 1'b1;
    tick();
    ClearCount = 1'b0;
    check("clear_in_run", 32'(CycleCount), 32'd0);
    ticks(254);
    check("count_254", 32'(CycleCount), 32'(cexp(254)));
    tick(); check("count_255", 32'(CycleCount), 32'(cexp(255)));
    tick(); check("count_wrap0", 32'(CycleCount), 32'd0);
    tick(); check("count_1", 32'(CycleCount), 32'(cexp(1)));
    check("clear_with_en_pre", 32'(CpuEn), 32'd1);
    ClearCount = 1'b1;
    tick();
    ClearCount = 1'b0;
    check("clear_over_inc", 32'(CycleCount), 32'd0);
    ticks(5);

    // Asynchronous reset mid-run and mid-debounce, then step after release
    StepBtn = 1'b1;
    ticks(3);
    #2 Reset = 1'b1;
    #1;
    check("async_rst_mode", 32'(Mode), 32'd0);
    check("async_rst_en", 32'(CpuEn), 32'd0);
    check("async_rst_count", 32'(CycleCount), 32'd0);
    Play = 1'b0;
    ticks(2);
    Reset = 1'b0;
    steps = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (Mode == 2'd1) steps++;
    end
    check("post_reset_step", 32'(steps), 32'd1);
    StepBtn = 1'b0;
    ticks(6);

    // Random panel activity
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(39) == 0) Play = ~Play;
      if ($urandom_range(29) == 0) FullSpeed = ~FullSpeed;
      if ($urandom_range(7) == 0) StepBtn = ~StepBtn;
      BreakHalt  = ($urandom_range(24) == 0);
      ClearCount = ($urandom_range(49) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
